// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants for the operand bypass network.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int SEL_REGFILE = 0;
  typedef enum int {STAGE_EX = 0, STAGE_MEM = 1, STAGE_WB = 2} stage_e;
endpackage

// File: rtl/bypass_select.sv
// bypass_select: picks the youngest in-flight writer of one source operand.
module bypass_select #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_RDY = 1,
  parameter int SEL_W = 2
) (
  input  logic [REG_AW-1:0]       rs_i,
  input  logic [XLEN-1:0]         rf_data_i,
  input  logic [DEPTH-1:0]        valid_i,
  input  logic [DEPTH*REG_AW-1:0] rd_i,
  input  logic [DEPTH-1:0]        load_i,
  input  logic [DEPTH*XLEN-1:0]   stage_data_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic [XLEN-1:0]         operand_o,
  output logic                    load_hazard_o
);
  import cpu_pkg::*;
  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    sel_o = SEL_W'(SEL_REGFILE);
    operand_o = rf_data_i;
    load_hazard_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_i[k] && rd_i[k*REG_AW +: REG_AW] == rs_i && rs_i != '0) begin
        sel_o = SEL_W'(k + 1);
        operand_o = stage_data_i[k*XLEN +: XLEN];
        load_hazard_o = load_i[k] && (k < LOAD_RDY);
      end
    end
  end
endmodule

// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard: in-flight writer tracking, operand forwarding and load-use stall.
module bypass_scoreboard #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int NUM_SRC = 2,
  parameter int DEPTH = int'(cpu_pkg::STAGE_WB) + 1,
  parameter int LOAD_RDY = int'(cpu_pkg::STAGE_MEM),
  parameter int CNT_W = 32,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_valid_i,
  input  logic                      flush_i,
  input  logic [REG_AW-1:0]         rd_i,
  input  logic                      reg_write_i,
  input  logic                      mem_read_i,
  input  logic [NUM_SRC*REG_AW-1:0] rs_i,
  input  logic [NUM_SRC*XLEN-1:0]   rf_data_i,
  input  logic [DEPTH*XLEN-1:0]     stage_data_i,
  output logic [NUM_SRC*XLEN-1:0]   operand_o,
  output logic [NUM_SRC*SEL_W-1:0]  select_o,
  output logic                      stall_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);
  if (DEPTH < 1 || LOAD_RDY > DEPTH || NUM_SRC < 1) begin : g_bad_params
    $error("bypass_scoreboard: invalid DEPTH/LOAD_RDY/NUM_SRC");
  end
  logic [DEPTH-1:0] valid_q, valid_d, load_q, load_d;
  logic [DEPTH*REG_AW-1:0] rd_q, rd_d;
  logic [NUM_SRC-1:0] hazard;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic push;
  assign stall_o = issue_valid_i & ~flush_i & |hazard;
  assign push = issue_valid_i & reg_write_i & (rd_i != '0) & ~flush_i & ~stall_o;
  // Entry 0 is the youngest; shifting up retires entry DEPTH-1.
  assign valid_d = DEPTH'({valid_q, push});
  assign load_d = DEPTH'({load_q, mem_read_i});
  assign rd_d = (DEPTH*REG_AW)'({rd_q, rd_i});
  assign cnt_d = cnt_q + CNT_W'(stall_o & ~&cnt_q);
  assign stall_cnt_o = cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      load_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      load_q <= load_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    bypass_select #(
      .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SEL_W(SEL_W)
    ) u_sel (
      .rs_i(rs_i[s*REG_AW +: REG_AW]),
      .rf_data_i(rf_data_i[s*XLEN +: XLEN]),
      .valid_i(valid_q),
      .rd_i(rd_q),
      .load_i(load_q),
      .stage_data_i(stage_data_i),
      .sel_o(select_o[s*SEL_W +: SEL_W]),
      .operand_o(operand_o[s*XLEN +: XLEN]),
      .load_hazard_o(hazard[s])
    );
  end
endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb_bypass_scoreboard: directed and random checks against a history-list model.
module tb_bypass_scoreboard;
  logic clk = 1'b0;
  logic rst, iv, fl, rw, mr;
  logic [4:0] rd;
  logic [9:0] rs;
  logic [63:0] rf, op, op_s;
  logic [95:0] sd;
  logic [3:0] sel, sel_s;
  logic stall, stall_s;
  logic [31:0] cnt;
  logic [1:0] cnt_s;
  int checks = 0, errors = 0;
  // Model: hist[k] describes the instruction issued k+1 cycles ago.
  typedef struct {bit v; bit [4:0] rd; bit ld;} rec_t;
  rec_t hist[3];
  int unsigned mcnt, mcnt_s;
  logic [1:0] esel[2];
  logic [31:0] eop[2];
  bit estall;

  always #5 clk = ~clk;

  bypass_scoreboard dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv), .flush_i(fl), .rd_i(rd),
    .reg_write_i(rw), .mem_read_i(mr), .rs_i(rs), .rf_data_i(rf), .stage_data_i(sd),
    .operand_o(op), .select_o(sel), .stall_o(stall), .stall_cnt_o(cnt)
  );
  bypass_scoreboard #(.CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv), .flush_i(fl), .rd_i(rd),
    .reg_write_i(rw), .mem_read_i(mr), .rs_i(rs), .rf_data_i(rf), .stage_data_i(sd),
    .operand_o(op_s), .select_o(sel_s), .stall_o(stall_s), .stall_cnt_o(cnt_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit f, input bit [4:0] d, input bit w, input bit m,
                       input bit [4:0] r0, input bit [4:0] r1);
    iv = v; fl = f; rd = d; rw = w; mr = m; rs = {r1, r0};
    rf = {$urandom, $urandom};
    sd = {$urandom, $urandom, $urandom};
  endtask

  task automatic eval();
    logic [4:0] r;
    bit haz;
    #2;
    haz = 0;
    for (int s = 0; s < 2; s++) begin
      r = rs[s*5 +: 5];
      esel[s] = 0;
      eop[s] = rf[s*32 +: 32];
      for (int k = 0; k < 3; k++)
        if (hist[k].v && hist[k].rd == r && r != 0) begin
          esel[s] = 2'(k + 1);
          eop[s] = sd[k*32 +: 32];
          if (hist[k].ld && k < 1) haz = 1;
          break;
        end
    end
    estall = iv && !fl && haz;
    chk("stall", stall, estall);
    chk("stall_s", stall_s, estall);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("sel%0d", s), sel[s*2 +: 2], esel[s]);
      chk($sformatf("sel_s%0d", s), sel_s[s*2 +: 2], esel[s]);
      if (!estall) chk($sformatf("op%0d", s), op[s*32 +: 32], eop[s]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (hist[k]) hist[k] = '{0, 0, 0};
      mcnt = 0;
      mcnt_s = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{iv && rw && rd != 0 && !fl && !estall, rd, mr};
      if (estall) begin
        mcnt++;
        if (mcnt_s < 3) mcnt_s++;
      end
    end
    #1;
    chk("cnt", cnt, mcnt);
    chk("cnt_s", cnt_s, mcnt_s);
  endtask

  initial begin
    rst = 1; estall = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    drive(1, 0, 0, 0, 0, 5, 9);
    eval();
    chk("post_rst_sel", sel, 0);
    chk("post_rst_op", op, rf);
    tick();
    // Writer in EX
    drive(1, 0, 5, 1, 0, 0, 0); eval(); tick();
    drive(1, 0, 0, 0, 0, 5, 0); sd[31:0] = 32'hA5A5; eval();
    chk("ex_sel0", sel[1:0], 1); chk("ex_op0", op[31:0], 32'hA5A5); chk("ex_stall", stall, 0);
    tick();
    // Priority: youngest writer wins
    drive(1, 0, 7, 1, 0, 0, 0); eval(); tick();
    drive(1, 0, 7, 1, 0, 0, 0); eval(); tick();
    drive(0, 0, 0, 0, 0, 0, 7); sd[31:0] = 32'h22; sd[63:32] = 32'h11; eval();
    chk("prio_sel1", sel[3:2], 1); chk("prio_op1", op[63:32], 32'h22);
    tick();
    drive(1, 0, 0, 0, 0, 0, 7); eval();
    chk("prio_old_sel1", sel[3:2], 2);
    tick();
    // Load-use
    drive(1, 0, 3, 1, 1, 0, 0); eval(); tick();
    drive(1, 0, 0, 0, 0, 3, 0); eval();
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_cnt", cnt, 1);
    eval();
    chk("lu_sel0", sel[1:0], 2); chk("lu_op0", op[31:0], sd[63:32]); chk("lu_nostall", stall, 0);
    tick();
    // x0 and regfile fallback
    drive(1, 0, 0, 1, 0, 0, 0); eval(); tick();
    drive(1, 0, 0, 0, 0, 0, 9); eval();
    chk("x0_sel0", sel[1:0], 0); chk("x0_op0", op[31:0], rf[31:0]); chk("nomatch_sel1", sel[3:2], 0);
    tick();
    // Flush beats hazard and issues a bubble
    drive(1, 0, 4, 1, 1, 0, 0); eval(); tick();
    drive(1, 1, 4, 1, 1, 4, 0); eval();
    chk("fl_stall", stall, 0);
    tick();
    drive(1, 0, 0, 0, 0, 4, 0); eval();
    chk("fl_bubble_sel0", sel[1:0], 2); chk("fl_nostall", stall, 0);
    tick();
    // Reset mid-stall
    drive(1, 0, 6, 1, 1, 0, 0); eval(); tick();
    drive(1, 0, 0, 0, 0, 6, 0); rst = 1; eval();
    chk("rst_mid_stall", stall, 1);
    tick();
    rst = 0;
    drive(1, 0, 0, 0, 0, 6, 0); eval();
    chk("rst_sel0", sel[1:0], 0); chk("rst_stall", stall, 0); chk("rst_cnt", cnt, 0);
    tick();
    // Saturation with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 3, 1, 1, 0, 0); eval(); tick();
      drive(1, 0, 0, 0, 0, 3, 0); eval(); tick();
      eval(); tick();
    end
    chk("sat_cnt_s", cnt_s, 3);
    chk("sat_cnt", cnt, 5);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      rst = $urandom_range(0, 99) == 0;
      eval();
      tick();
    end
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
